ysyx_040729_div_ctrl: RTL
=========================

Name: ysyx_040729_div_ctrl

Overview:
Multi-cycle control stage that sits directly upstream of the EXU's purely combinational unsigned divider core. It accepts RV64M divide requests (DIV/DIVU/REM/REMU and their W forms) over a valid/ready handshake and converts operands to unsigned magnitudes. It holds those magnitudes stable on the core inputs for a fixed multicycle window, then applies sign correction and the RISC-V special cases. The result is buffered until the consumer (EXU writeback mux) takes it.

Parameters:
XLEN, 64, datapath width; the core is instantiated with both widths = XLEN.
LATENCY, 4, cycles the core inputs are held before its outputs are sampled (multicycle-path budget, >=1).

Ports:
clock  input  1  single clock, all state on rising edge.
reset  input  1  asynchronous, active-high reset.
flush  input  1  pipeline kill; abandons any in-flight or buffered operation.
in_valid  input  1  request valid.
in_ready  output  1  request accepted when in_valid & in_ready.
op  input  2  00 DIV, 01 DIVU, 10 REM, 11 REMU.
word  input  1  W variant (32-bit operation).
src1  input  XLEN  dividend.
src2  input  XLEN  divisor.
div_dividend  output  XLEN  unsigned magnitude to core.
div_divisor  output  XLEN  unsigned magnitude to core.
div_quotient  input  XLEN  core quotient.
div_remainder  input  XLEN  core remainder.
out_valid  output  1  result valid.
out_ready  input  1  consumer accepts when out_valid & out_ready.
result  output  XLEN  final value.

Behaviour:
- Reset (async): state IDLE, counter 0, in_ready=1, out_valid=0, result=0, div_dividend=0, div_divisor=0.
- States: IDLE, CALC, DONE.
- IDLE: in_ready=1. On accept, latch op, word, operand signs and magnitudes.
  - Special case detected: write result directly and go to DONE.
  - Otherwise: load counter with LATENCY-1 and go to CALC.
- W extension, applied before any processing: signed ops sign-extend src[31:0]; unsigned ops zero-extend src[31:0]. Effective width for the overflow test is 32.
- Magnitude: for signed ops, a negative operand is two's-complement negated; unsigned ops pass through. The dividend magnitude of the most-negative value is its own bit pattern. That case only reaches the core when the divisor is not -1 and it is correct there.
- CALC: in_ready=0. div_* registers are held constant. Counter decrements each cycle. When counter==0, sample the core outputs and select the quotient (DIV/DIVU) or remainder (REM/REMU).
  - Negate the quotient iff signed and the operand signs differ.
  - Negate the remainder iff signed and the dividend is negative.
  - Register the corrected value into result and go to DONE.
- W results: result = sign-extend(bit 31 of the corrected 32-bit value), for signed and unsigned ops alike.
- Special cases (RISC-V M spec):
  - Divisor==0: DIV/DIVU -> all ones (W: 0xFFFFFFFF sign-extended = all ones). REM/REMU -> the extended dividend, W-result rule applied.
  - Signed overflow (dividend = most negative of the effective width, divisor = -1): DIV -> the dividend (W: sign-extended 0x80000000). REM -> 0.
- DONE: out_valid=1 and result is held stable until out_ready. On out_ready go to IDLE; in_ready rises the next cycle (no same-cycle re-accept).
- Latency from the accept edge to out_valid high: special case 1 cycle; normal LATENCY+1 cycles.
- flush: from any state go to IDLE next cycle; out_valid is deasserted and the buffered result is discarded. flush together with in_valid in IDLE means the request is dropped. flush outranks out_ready.
- Reset mid-operation: immediate return to reset values; nothing is retained.

Decomposition:
- Shared package holds:
  - op encodings DIV_OP_DIV/DIVU/REM/REMU.
  - state encoding for IDLE/CALC/DONE.
  - The LATENCY default.
- One natural combinational sub-module, ysyx_040729_div_fixup. It takes signed, word, the sign flags, the operation select and the core outputs, and produces the sign-corrected, W-extended result. The special-case detection also lives there so the checks can be unit-tested in isolation.
- The FSM, counter and handshake registers stay in the top.

Test Plan:
- DIV src1=-7 (0xFFFFFFFFFFFFFFF9), src2=2, LATENCY=4 -> out_valid 5 cycles after accept, result 0xFFFFFFFFFFFFFFFD (-3). Same operands with REM -> 0xFFFFFFFFFFFFFFFF (-1).
- DIVU src1=123, src2=0 -> out_valid 1 cycle after accept, result 0xFFFFFFFFFFFFFFFF. REMU, same operands -> 123.
- DIVW src1=0x0000000080000000, src2=0xFFFFFFFFFFFFFFFF -> 0xFFFFFFFF80000000. REMW, same operands -> 0.
- REMUW src1=0xFFFFFFFF_FFFFFFFF, src2=0x10 -> 0x000000000000000F. DIVUW, same operands -> 0x000000000FFFFFFF.
- Backpressure: DIV 100/7 with out_ready held low 3 cycles after out_valid -> result stays 14, in_ready stays 0, and a second in_valid is not accepted until the cycle after the out_ready handshake.
- flush 2 cycles into CALC -> IDLE next cycle, out_valid never asserts. Async reset pulse in DONE -> out_valid=0 and result=0 without waiting for a clock edge.

Source files
------------

// File: rtl/ysyx_040729_div_ctrl_pkg.sv
// ysyx_040729_div_ctrl_pkg: shared encodings and defaults for the divider control stage.
package ysyx_040729_div_ctrl_pkg;
   localparam logic [1:0] DIV_OP_DIV  = 2'b00;
   localparam logic [1:0] DIV_OP_DIVU = 2'b01;
   localparam logic [1:0] DIV_OP_REM  = 2'b10;
   localparam logic [1:0] DIV_OP_REMU = 2'b11;
   localparam int DIV_LATENCY = 4;
   typedef enum logic [1:0] {ST_IDLE, ST_CALC, ST_DONE} div_state_e;
endpackage

// File: rtl/ysyx_040729_div_fixup.sv
// ysyx_040729_div_fixup: RISC-V special-case detection plus sign correction and W extension of core outputs.
module ysyx_040729_div_fixup
   import ysyx_040729_div_ctrl_pkg::*;
#(
   parameter int XLEN = 64
) (
   input  logic [1:0]      op_i,
   input  logic            word_i,
   input  logic            neg1_i,
   input  logic            neg2_i,
   input  logic [XLEN-1:0] dividend_i,
   input  logic [XLEN-1:0] divisor_i,
   input  logic [XLEN-1:0] quotient_i,
   input  logic [XLEN-1:0] remainder_i,
   output logic            special_o,
   output logic [XLEN-1:0] special_res_o,
   output logic [XLEN-1:0] result_o
);
   logic sgn, rem, div0, ovf, neg;
   logic [XLEN-1:0] min_val, sp, sel, corr;
   assign sgn = (op_i == DIV_OP_DIV) || (op_i == DIV_OP_REM);
   assign rem = (op_i == DIV_OP_REM) || (op_i == DIV_OP_REMU);
   // dividend/divisor arrive already W-extended, so the most-negative test follows the effective width
   assign min_val = word_i ? {{(XLEN-31){1'b1}}, 31'b0} : {1'b1, {(XLEN-1){1'b0}}};
   assign div0 = divisor_i == '0;
   assign ovf = sgn && dividend_i == min_val && &divisor_i;
   assign special_o = div0 || ovf;
   assign sp = div0 ? (rem ? dividend_i : '1) : (rem ? '0 : dividend_i);
   assign special_res_o = word_i ? {{(XLEN-32){sp[31]}}, sp[31:0]} : sp;
   assign sel = rem ? remainder_i : quotient_i;
   assign neg = sgn && (rem ? neg1_i : neg1_i ^ neg2_i);
   assign corr = neg ? -sel : sel;
   assign result_o = word_i ? {{(XLEN-32){corr[31]}}, corr[31:0]} : corr;
endmodule

// File: rtl/ysyx_040729_div_ctrl.sv
// ysyx_040729_div_ctrl: multicycle valid/ready control around a combinational unsigned divider core.
module ysyx_040729_div_ctrl
   import ysyx_040729_div_ctrl_pkg::*;
#(
   parameter int XLEN    = 64,
   parameter int LATENCY = DIV_LATENCY
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [1:0]      op,
   input  logic            word,
   input  logic [XLEN-1:0] src1,
   input  logic [XLEN-1:0] src2,
   output logic [XLEN-1:0] div_dividend,
   output logic [XLEN-1:0] div_divisor,
   input  logic [XLEN-1:0] div_quotient,
   input  logic [XLEN-1:0] div_remainder,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result
);
   localparam int CW = $clog2(LATENCY + 1);
   div_state_e state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [1:0] op_q, op_d;
   logic word_q, word_d, neg1_q, neg1_d, neg2_q, neg2_d;
   logic [XLEN-1:0] dvd_q, dvd_d, dvs_q, dvs_d, res_q, res_d;
   logic [XLEN-1:0] ext1, ext2, mag1, mag2, spec_res, fix_res;
   logic sgn, neg1, neg2, idle, special;
   assign sgn = ~op[0];
   assign ext1 = word ? {{(XLEN-32){sgn & src1[31]}}, src1[31:0]} : src1;
   assign ext2 = word ? {{(XLEN-32){sgn & src2[31]}}, src2[31:0]} : src2;
   assign neg1 = sgn & ext1[XLEN-1];
   assign neg2 = sgn & ext2[XLEN-1];
   assign mag1 = neg1 ? -ext1 : ext1;
   assign mag2 = neg2 ? -ext2 : ext2;
   assign idle = state_q == ST_IDLE;
   assign in_ready = idle;
   assign out_valid = state_q == ST_DONE;
   assign div_dividend = dvd_q;
   assign div_divisor = dvs_q;
   assign result = res_q;
   // special-case checks look at the live request; correction uses the latched one
   ysyx_040729_div_fixup #(.XLEN(XLEN)) u_fixup (
      .op_i          (idle ? op : op_q),
      .word_i        (idle ? word : word_q),
      .neg1_i        (neg1_q),
      .neg2_i        (neg2_q),
      .dividend_i    (ext1),
      .divisor_i     (ext2),
      .quotient_i    (div_quotient),
      .remainder_i   (div_remainder),
      .special_o     (special),
      .special_res_o (spec_res),
      .result_o      (fix_res)
   );
   always_comb begin
      state_d = state_q;
      cnt_d = cnt_q;
      op_d = op_q;
      word_d = word_q;
      neg1_d = neg1_q;
      neg2_d = neg2_q;
      dvd_d = dvd_q;
      dvs_d = dvs_q;
      res_d = res_q;
      if (flush) begin
         state_d = ST_IDLE;
         res_d = '0;
      end else if (idle && in_valid) begin
         op_d = op;
         word_d = word;
         neg1_d = neg1;
         neg2_d = neg2;
         if (special) begin
            res_d = spec_res;
            state_d = ST_DONE;
         end else begin
            dvd_d = mag1;
            dvs_d = mag2;
            cnt_d = CW'(LATENCY - 1);
            state_d = ST_CALC;
         end
      end else if (state_q == ST_CALC) begin
         cnt_d = cnt_q - 1'b1;
         if (cnt_q == '0) begin
            cnt_d = '0;
            res_d = fix_res;
            state_d = ST_DONE;
         end
      end else if (out_valid && out_ready) begin
         state_d = ST_IDLE;
      end
   end
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         cnt_q <= '0;
         op_q <= '0;
         word_q <= 1'b0;
         neg1_q <= 1'b0;
         neg2_q <= 1'b0;
         dvd_q <= '0;
         dvs_q <= '0;
         res_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q <= cnt_d;
         op_q <= op_d;
         word_q <= word_d;
         neg1_q <= neg1_d;
         neg2_q <= neg2_d;
         dvd_q <= dvd_d;
         dvs_q <= dvs_d;
         res_q <= res_d;
      end
   end
endmodule
